// File: rtl/ms_wb_splitter.sv
// Registered Wishbone classic-cycle splitter: one master, NS slaves decoded on adr[19:16].
// Optional REQ timeout guarded by macro WB_SPLITTER_TIMEOUT_EN.
module ms_wb_splitter #(
    parameter int unsigned NS           = 3,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] DEFAULT_DATA = 32'hDEADBEEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              s_cyc_o,
    output logic [NS-1:0]     s_stb_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic [31:0]       s_adr_o,
    output logic [31:0]       s_dat_o,
    input  logic [NS-1:0]     s_ack_i,
    input  logic [NS*32-1:0]  s_dat_i,
    input  logic              err_clr_i,
    output logic              err_irq_o,
    output logic [1:0]        err_cause_o
);

    if (NS < 1 || NS > 8) begin : g_bad_ns
        $error("ms_wb_splitter: NS must be 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("ms_wb_splitter: TIMEOUT must be 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  idx;
    logic        req;
    logic [2:0]  dec_idx;
    logic        dec_hit;
    logic        sel_ack;
    logic [31:0] sel_dat;
    logic        timeout_hit;
    logic        set_unmapped;
    logic        set_timeout;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign dec_idx = wbs_adr_i[19:17];
    // Slave k sits at even nibble 2*k, so bit 16 set means unmapped.
    assign dec_hit = !wbs_adr_i[16] && (32'(dec_idx) < NS);

    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (idx == 3'(k)) begin
                sel_ack = s_ack_i[k];
                sel_dat = s_dat_i[32*k +: 32];
            end
        end
    end

`ifdef WB_SPLITTER_TIMEOUT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else begin
            cnt <= (state == REQ) ? cnt + 16'd1 : '0;
        end
    end

    assign timeout_hit = (state == REQ) && (cnt == 16'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // An ack arriving in the expiry cycle takes precedence over the timeout.
    assign set_unmapped = (state == IDLE) && req && !dec_hit;
    assign set_timeout  = (state == REQ) && wbs_cyc_i && !sel_ack && timeout_hit;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = dec_hit ? REQ : RESP;
                end
            end
            REQ: begin
                if (!wbs_cyc_i) begin
                    next_state = IDLE;
                end else if (sel_ack || timeout_hit) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o   = (state == REQ);
        wbs_ack_o = (state == RESP);
        s_stb_o   = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            if ((state == REQ) && (idx == 3'(k))) begin
                s_stb_o[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            idx         <= '0;
            s_we_o      <= 1'b0;
            s_sel_o     <= '0;
            s_adr_o     <= '0;
            s_dat_o     <= '0;
            wbs_dat_o   <= '0;
            err_irq_o   <= 1'b0;
            err_cause_o <= '0;
        end else begin
            if ((state == IDLE) && req) begin
                idx     <= dec_idx;
                s_we_o  <= wbs_we_i;
                s_sel_o <= wbs_sel_i;
                s_adr_o <= wbs_adr_i;
                s_dat_o <= wbs_dat_i;
                if (!dec_hit) begin
                    wbs_dat_o <= DEFAULT_DATA;
                end
            end
            if ((state == REQ) && wbs_cyc_i) begin
                if (sel_ack) begin
                    wbs_dat_o <= sel_dat;
                end else if (timeout_hit) begin
                    wbs_dat_o <= DEFAULT_DATA;
                end
            end
            if (set_unmapped || set_timeout) begin
                err_irq_o   <= 1'b1;
                err_cause_o <= set_timeout ? 2'b10 : 2'b01;
            end else if (err_clr_i) begin
                err_irq_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ms_wb_splitter.sv
// Directed self-checking bench for ms_wb_splitter (NS=3, TIMEOUT=8).
module tb_ms_wb_splitter;

    localparam int unsigned NS = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wbs_cyc = 1'b0;
    logic              wbs_stb = 1'b0;
    logic              wbs_we = 1'b0;
    logic [3:0]        wbs_sel = '0;
    logic [31:0]       wbs_adr = '0;
    logic [31:0]       wbs_wdat = '0;
    logic              wbs_ack;
    logic [31:0]       wbs_rdat;
    logic              s_cyc;
    logic [NS-1:0]     s_stb;
    logic              s_we;
    logic [3:0]        s_sel;
    logic [31:0]       s_adr;
    logic [31:0]       s_wdat;
    logic [NS-1:0]     s_ack = '0;
    logic [NS*32-1:0]  s_rdat = '0;
    logic              err_clr = 1'b0;
    logic              err_irq;
    logic [1:0]        err_cause;

    int n_tests = 0;
    int n_fail  = 0;

    ms_wb_splitter #(
        .NS(NS),
        .TIMEOUT(8),
        .DEFAULT_DATA(32'hDEADBEEF)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .wbs_cyc_i(wbs_cyc),
        .wbs_stb_i(wbs_stb),
        .wbs_we_i(wbs_we),
        .wbs_sel_i(wbs_sel),
        .wbs_adr_i(wbs_adr),
        .wbs_dat_i(wbs_wdat),
        .wbs_ack_o(wbs_ack),
        .wbs_dat_o(wbs_rdat),
        .s_cyc_o(s_cyc),
        .s_stb_o(s_stb),
        .s_we_o(s_we),
        .s_sel_o(s_sel),
        .s_adr_o(s_adr),
        .s_dat_o(s_wdat),
        .s_ack_i(s_ack),
        .s_dat_i(s_rdat),
        .err_clr_i(err_clr),
        .err_irq_o(err_irq),
        .err_cause_o(err_cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [31:0] adr, input logic we,
                             input logic [31:0] dat, input logic [3:0] sel);
        wbs_adr  = adr;
        wbs_we   = we;
        wbs_wdat = dat;
        wbs_sel  = sel;
        wbs_cyc  = 1'b1;
        wbs_stb  = 1'b1;
    endtask

    task automatic end_req();
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        s_ack   = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({wbs_ack, s_cyc, s_stb, err_irq, err_cause} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b required 00000000", {wbs_ack, s_cyc, s_stb, err_irq, err_cause});
            n_fail++;
        end
        n_tests++;
        if ({wbs_rdat, s_adr, s_wdat, s_sel, s_we} !== 101'd0) begin
            $display("FAIL reset_data: got %h/%h/%h/%h/%b required all zero", wbs_rdat, s_adr, s_wdat, s_sel, s_we);
            n_fail++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_timer_read();
        start_req(32'h3000_0004, 1'b0, 32'h0, 4'hF);
        tick();
        n_tests++;
        if ({s_cyc, s_stb, wbs_ack} !== 5'b1_001_0) begin
            $display("FAIL timer_req: cyc/stb/ack got %b required 10010", {s_cyc, s_stb, wbs_ack});
            n_fail++;
        end
        s_ack = 3'b001;
        s_rdat[31:0] = 32'h1234_5678;
        tick();
        n_tests++;
        if ({wbs_ack, s_stb, s_cyc} !== 5'b1_000_0 || wbs_rdat !== 32'h1234_5678) begin
            $display("FAIL timer_resp: ack/stb/cyc %b dat %h required 10000 12345678", {wbs_ack, s_stb, s_cyc}, wbs_rdat);
            n_fail++;
        end
        n_tests++;
        if (err_irq !== 1'b0) begin
            $display("FAIL timer_err: got %b required 0", err_irq);
            n_fail++;
        end
        end_req();
        tick();
        n_tests++;
        if (wbs_ack !== 1'b0 || wbs_rdat !== 32'h1234_5678) begin
            $display("FAIL timer_hold: ack %b dat %h required 0 12345678", wbs_ack, wbs_rdat);
            n_fail++;
        end
    endtask

    task automatic test_psram_write();
        start_req(32'h3004_0010, 1'b1, 32'hA5A5_A5A5, 4'hF);
        tick();
        wbs_wdat = 32'h0;
        wbs_adr  = 32'h0;
        wbs_sel  = 4'h0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (s_stb !== 3'b100 || s_cyc !== 1'b1 || wbs_ack !== 1'b0) begin
                $display("FAIL psram_stb[%0d]: stb %b cyc %b ack %b required 100 1 0", i, s_stb, s_cyc, wbs_ack);
                n_fail++;
            end
            n_tests++;
            if (s_wdat !== 32'hA5A5_A5A5 || s_adr !== 32'h3004_0010 || s_sel !== 4'hF || s_we !== 1'b1) begin
                $display("FAIL psram_latch[%0d]: dat %h adr %h sel %h we %b required a5a5a5a5 30040010 f 1",
                         i, s_wdat, s_adr, s_sel, s_we);
                n_fail++;
            end
            if (i == 4) begin
                s_ack = 3'b100;
                s_rdat[95:64] = 32'h0000_00A5;
            end
            tick();
        end
        n_tests++;
        if (wbs_ack !== 1'b1 || s_stb !== 3'b000 || wbs_rdat !== 32'h0000_00A5) begin
            $display("FAIL psram_resp: ack %b stb %b dat %h required 1 000 000000a5", wbs_ack, s_stb, wbs_rdat);
            n_fail++;
        end
        end_req();
        tick();
    endtask

    task automatic test_stray_ack();
        start_req(32'h3004_0000, 1'b0, 32'h0, 4'hF);
        tick();
        s_ack = 3'b001;
        s_rdat[31:0]  = 32'h1111_1111;
        s_rdat[95:64] = 32'hC0FF_EE00;
        tick();
        n_tests++;
        if (s_stb !== 3'b100 || wbs_ack !== 1'b0) begin
            $display("FAIL stray_ignored: stb %b ack %b required 100 0", s_stb, wbs_ack);
            n_fail++;
        end
        s_ack = 3'b101;
        tick();
        n_tests++;
        if (wbs_ack !== 1'b1 || wbs_rdat !== 32'hC0FF_EE00) begin
            $display("FAIL stray_resp: ack %b dat %h required 1 c0ffee00", wbs_ack, wbs_rdat);
            n_fail++;
        end
        end_req();
        tick();
    endtask

    task automatic test_unmapped();
        start_req(32'h3001_0000, 1'b0, 32'h0, 4'hF);
        tick();
        n_tests++;
        if (wbs_ack !== 1'b1 || wbs_rdat !== 32'hDEADBEEF || s_stb !== 3'b000 || s_cyc !== 1'b0) begin
            $display("FAIL unmapped_resp: ack %b dat %h stb %b cyc %b required 1 deadbeef 000 0",
                     wbs_ack, wbs_rdat, s_stb, s_cyc);
            n_fail++;
        end
        n_tests++;
        if (err_irq !== 1'b1 || err_cause !== 2'b01) begin
            $display("FAIL unmapped_err: irq %b cause %b required 1 01", err_irq, err_cause);
            n_fail++;
        end
        end_req();
        tick();
        n_tests++;
        if (err_irq !== 1'b1 || wbs_ack !== 1'b0) begin
            $display("FAIL unmapped_sticky: irq %b ack %b required 1 0", err_irq, wbs_ack);
            n_fail++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++;
        if (err_irq !== 1'b0) begin
            $display("FAIL err_clear: irq %b required 0", err_irq);
            n_fail++;
        end
        // adr[19:16] = 6 is past the last slave; clear asserted alongside must lose
        start_req(32'h3006_0000, 1'b0, 32'h0, 4'hF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++;
        if (wbs_ack !== 1'b1 || wbs_rdat !== 32'hDEADBEEF || err_irq !== 1'b1 || err_cause !== 2'b01) begin
            $display("FAIL unmapped_high_set_wins: ack %b dat %h irq %b cause %b required 1 deadbeef 1 01",
                     wbs_ack, wbs_rdat, err_irq, err_cause);
            n_fail++;
        end
        end_req();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

`ifdef WB_SPLITTER_TIMEOUT_EN
    task automatic test_timeout();
        start_req(32'h3002_0000, 1'b0, 32'h0, 4'hF);
        s_rdat[63:32] = 32'h5151_5151;
        tick();
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (s_stb !== 3'b010 || wbs_ack !== 1'b0) begin
                $display("FAIL timeout_stb[%0d]: stb %b ack %b required 010 0", i, s_stb, wbs_ack);
                n_fail++;
            end
            tick();
        end
        n_tests++;
        if (wbs_ack !== 1'b1 || s_stb !== 3'b000 || s_cyc !== 1'b0 || wbs_rdat !== 32'hDEADBEEF
            || err_irq !== 1'b1 || err_cause !== 2'b10) begin
            $display("FAIL timeout_resp: ack %b stb %b cyc %b dat %h irq %b cause %b required 1 000 0 deadbeef 1 10",
                     wbs_ack, s_stb, s_cyc, wbs_rdat, err_irq, err_cause);
            n_fail++;
        end
        end_req();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        start_req(32'h3002_0000, 1'b0, 32'h0, 4'hF);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) s_ack = 3'b010;
            tick();
        end
        n_tests++;
        if (wbs_ack !== 1'b1 || wbs_rdat !== 32'h5151_5151 || err_irq !== 1'b0) begin
            $display("FAIL timeout_ack_wins: ack %b dat %h irq %b required 1 51515151 0", wbs_ack, wbs_rdat, err_irq);
            n_fail++;
        end
        end_req();
        tick();
    endtask
`else
    task automatic test_timeout();
        start_req(32'h3002_0000, 1'b0, 32'h0, 4'hF);
        s_rdat[63:32] = 32'h5151_5151;
        tick();
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (s_stb !== 3'b010 || wbs_ack !== 1'b0) begin
                $display("FAIL no_timeout_wait[%0d]: stb %b ack %b required 010 0", i, s_stb, wbs_ack);
                n_fail++;
            end
            tick();
        end
        s_ack = 3'b010;
        tick();
        n_tests++;
        if (wbs_ack !== 1'b1 || wbs_rdat !== 32'h5151_5151 || err_irq !== 1'b0) begin
            $display("FAIL no_timeout_resp: ack %b dat %h irq %b required 1 51515151 0", wbs_ack, wbs_rdat, err_irq);
            n_fail++;
        end
        end_req();
        tick();
    endtask
`endif

    task automatic test_abort_reset();
        start_req(32'h3002_0000, 1'b0, 32'h0, 4'hF);
        tick();
        end_req();
        tick();
        n_tests++;
        if (s_stb !== 3'b000 || s_cyc !== 1'b0 || wbs_ack !== 1'b0) begin
            $display("FAIL abort_drop: stb %b cyc %b ack %b required 000 0 0", s_stb, s_cyc, wbs_ack);
            n_fail++;
        end
        tick();
        n_tests++;
        if (wbs_ack !== 1'b0) begin
            $display("FAIL abort_noack: ack %b required 0", wbs_ack);
            n_fail++;
        end
        start_req(32'h3002_0000, 1'b0, 32'h0, 4'hF);
        s_rdat[63:32] = 32'h2222_3333;
        tick();
        s_ack = 3'b010;
        tick();
        n_tests++;
        if (wbs_ack !== 1'b1 || wbs_rdat !== 32'h2222_3333) begin
            $display("FAIL abort_next: ack %b dat %h required 1 22223333", wbs_ack, wbs_rdat);
            n_fail++;
        end
        end_req();
        tick();
        start_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
        tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (s_stb !== 3'b000 || s_cyc !== 1'b0 || wbs_ack !== 1'b0 || wbs_rdat !== 32'h0) begin
            $display("FAIL rst_drop: stb %b cyc %b ack %b dat %h required 000 0 0 00000000", s_stb, s_cyc, wbs_ack, wbs_rdat);
            n_fail++;
        end
        end_req();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (wbs_ack !== 1'b0 || s_cyc !== 1'b0) begin
            $display("FAIL rst_noack: ack %b cyc %b required 0 0", wbs_ack, s_cyc);
            n_fail++;
        end
        start_req(32'h3000_0008, 1'b0, 32'h0, 4'hF);
        s_rdat[31:0] = 32'h4444_5555;
        tick();
        s_ack = 3'b001;
        tick();
        n_tests++;
        if (wbs_ack !== 1'b1 || wbs_rdat !== 32'h4444_5555) begin
            $display("FAIL rst_next: ack %b dat %h required 1 44445555", wbs_ack, wbs_rdat);
            n_fail++;
        end
        end_req();
        tick();
    endtask

    initial begin
        test_reset();
        test_timer_read();
        test_psram_write();
        test_stray_ack();
        test_unmapped();
        test_timeout();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ms_wb_splitter.md
# ms_wb_splitter

Registered Wishbone classic-cycle splitter between the Caravel user-area Wishbone slave port and the peripheral IPs (timer, UART, PSRAM controller). Decodes `adr[19:16]`, forwards one transaction at a time to the selected peripheral, and returns its ack/data to the master. Unmapped addresses and hung slaves are answered with a default word and flagged on a sticky error interrupt.

## Interface
- `NS`, 3: number of downstream slaves. Slave k decodes at `adr[19:16] == 2*k` (0x3000_0000, 0x3002_0000, 0x3004_0000 for NS=3).
- `TIMEOUT`, 255: maximum REQ cycles to wait for a slave ack; range 1..65535.
- `DEFAULT_DATA`, 32'hDEADBEEF: read data returned on an unmapped access or a timeout.

Ports:
- `clk_i` in 1: clock; all state changes on its rising edge.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: master cycle, strobe and write-enable.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i`, `wbs_dat_i` in 32: master address and write data.
- `wbs_ack_o` out 1: acknowledge to the master.
- `wbs_dat_o` out 32: read data to the master.
- `s_cyc_o` out 1: cycle to the slaves.
- `s_stb_o` out NS: one-hot strobe, one bit per slave.
- `s_we_o` out 1, `s_sel_o` out 4, `s_adr_o` out 32, `s_dat_o` out 32: latched request, shared by all slaves.
- `s_ack_i` in NS: per-slave acknowledge.
- `s_dat_i` in NS*32: per-slave read data; slave k occupies bits [32k+31:32k].
- `err_clr_i` in 1: clears `err_irq_o`.
- `err_irq_o` out 1: sticky error flag (unmapped access or timeout).
- `err_cause_o` out 2: cause of the last error. 01 = unmapped, 10 = timeout.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - Trigger: `wbs_cyc_i & wbs_stb_i`.
  - Latch adr, dat, sel, we and the decoded slave index.
  - Mapped address: go to REQ.
  - Unmapped address (`adr[19:16]` odd or ≥ 2*NS): go to RESP with `DEFAULT_DATA`. Set `err_irq_o`; set `err_cause_o` = 01.
- **REQ**
  - Drive `s_cyc_o` = 1 and `s_stb_o[idx]` = 1; all other stb bits are 0. The counter starts at 0.
  - `s_ack_i[idx]`: latch `s_dat_i[idx]` and go to RESP.
  - Acks from non-selected slaves are ignored.
  - `wbs_cyc_i` deasserted (abort): return to IDLE with no master ack.
- **RESP**
  - Assert `wbs_ack_o` for exactly one cycle; `wbs_dat_o` holds the latched word.
  - Always returns to IDLE.
- A new request is accepted only in IDLE; the master is expected to drop stb after ack.
- `wbs_dat_o` holds its last value outside RESP.
- Writes also pass through RESP. The returned data is whatever the slave drove.
- `err_irq_o` precedence: if a set condition and `err_clr_i` occur in the same cycle, set wins.
- Reset values:
  - State IDLE; counter 0.
  - `wbs_ack_o` = 0, `wbs_dat_o` = 0.
  - `s_cyc_o` = 0, `s_stb_o` = 0, `s_we_o` = 0, `s_sel_o` = 0, `s_adr_o` = 0, `s_dat_o` = 0.
  - `err_irq_o` = 0, `err_cause_o` = 00.
- Reset asserted mid-transaction returns the block to IDLE on the next edge. Strobes drop; no ack is issued.

## Timing
- Mapped access, slave acking in the first REQ cycle:
  - Cycle 0: IDLE samples the request.
  - Cycle 1: REQ, slave ack.
  - Cycle 2: `wbs_ack_o`.
  - Total: 2 cycles from stb to ack.
- General mapped case: a slave ack in REQ cycle n gives `wbs_ack_o` at REQ entry + n + 1.
- Unmapped access: `wbs_ack_o` 1 cycle after stb is sampled.
- Outputs are fully registered; there is no combinational path from `s_ack_i` to `wbs_ack_o`.
- Back-to-back: minimum 3 cycles per mapped transaction (IDLE, REQ, RESP).

## Configuration
- Macro `WB_SPLITTER_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter increments each REQ cycle.
  - When the counter reaches `TIMEOUT - 1` with no ack, `s_stb_o` and `s_cyc_o` drop.
  - The FSM goes to RESP with `DEFAULT_DATA`. `err_irq_o` is set; `err_cause_o` = 10.
  - An ack in the same cycle as expiry wins; the access is not a timeout.
- **Undefined:**
  - No counter is built; REQ waits indefinitely.
  - Cause 10 is never produced.

## Test plan
- **Timer read:** adr 0x3000_0004, slave 0 acks in the first REQ cycle with 0x1234_5678. Required: `s_stb_o` = 001 for 1 cycle; `wbs_ack_o` 2 cycles after stb with `wbs_dat_o` = 0x1234_5678; `err_irq_o` = 0.
- **PSRAM write:** adr 0x3004_0010, dat 0xA5A5_A5A5, sel 0xF, slave 2 acks after 5 cycles. Required: `s_stb_o` = 100 for 5 cycles; `s_dat_o`, `s_adr_o` and `s_sel_o` stable throughout; `wbs_ack_o` 1 cycle after the slave ack.
- **Unmapped read:** adr 0x3001_0000. Required: `wbs_ack_o` 1 cycle later with `wbs_dat_o` = 0xDEADBEEF; `s_stb_o` stays 000; `err_irq_o` = 1; `err_cause_o` = 01. Then pulse `err_clr_i` and `err_irq_o` returns to 0.
- **Timeout (macro defined, TIMEOUT = 8):** slave 1 never acks. Required: `s_stb_o` = 010 for exactly 8 cycles; then `wbs_ack_o` with 0xDEADBEEF, `err_cause_o` = 10. Repeat with an ack in the 8th REQ cycle: slave data is returned and no error is flagged.
- **Abort and reset:** drop `wbs_cyc_i` during REQ, and separately pull `rst_n_i` low during REQ. Required in both cases: stb and cyc are 0 on the next edge, no `wbs_ack_o` is issued, and the next request is served normally.
- **Stray ack:** slave 0 asserts ack while slave 2 is selected. Required: the stray ack is ignored; the response carries slave 2's data.
